// File: rtl/mc8051_mem_arb_if.sv
// Bus bundle for the mc8051 external-memory arbiter: two requesting masters,
// one shared slave port, plus owner/timeout status and FSM debug visibility.
interface mc8051_mem_arb_if;
  // Handshake: a master raises a request by pulling any of we_n/rd_n/psen_n
  // low and keeps all of its strobes, addr and wdata stable until its
  // one-cycle o_*_data_rdy pulse; o_*_rdata is valid in that same cycle.
  // On the slave side, mem_data_rdy is honoured only while a mem strobe is low.
  logic        i_cpu_we_n;
  logic        i_cpu_rd_n;
  logic        i_cpu_psen_n;
  logic        i_cpu_sfr_n;
  logic [15:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic [7:0]  o_cpu_rdata;
  logic        o_cpu_data_rdy;

  logic        i_aux_we_n;
  logic        i_aux_rd_n;
  logic        i_aux_psen_n;
  logic        i_aux_sfr_n;
  logic [15:0] i_aux_addr;
  logic [7:0]  i_aux_wdata;
  logic [7:0]  o_aux_rdata;
  logic        o_aux_data_rdy;

  logic        mem_we_n;
  logic        mem_rd_n;
  logic        mem_psen_n;
  logic        mem_sfr_n;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_data_rdy;

  logic [1:0]  o_owner;
  logic        o_timeout_err;

  logic [1:0]  fsm_state;
  logic [7:0]  starve_cnt;

  modport slave (
    input  i_cpu_we_n, i_cpu_rd_n, i_cpu_psen_n, i_cpu_sfr_n, i_cpu_addr, i_cpu_wdata,
    output o_cpu_rdata, o_cpu_data_rdy,
    input  i_aux_we_n, i_aux_rd_n, i_aux_psen_n, i_aux_sfr_n, i_aux_addr, i_aux_wdata,
    output o_aux_rdata, o_aux_data_rdy,
    output mem_we_n, mem_rd_n, mem_psen_n, mem_sfr_n, mem_addr, mem_wdata,
    input  mem_rdata, mem_data_rdy,
    output o_owner, o_timeout_err, fsm_state, starve_cnt
  );

  modport master (
    output i_cpu_we_n, i_cpu_rd_n, i_cpu_psen_n, i_cpu_sfr_n, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_rdata, o_cpu_data_rdy,
    output i_aux_we_n, i_aux_rd_n, i_aux_psen_n, i_aux_sfr_n, i_aux_addr, i_aux_wdata,
    input  o_aux_rdata, o_aux_data_rdy,
    input  mem_we_n, mem_rd_n, mem_psen_n, mem_sfr_n, mem_addr, mem_wdata,
    output mem_rdata, mem_data_rdy,
    input  o_owner, o_timeout_err, fsm_state, starve_cnt
  );
endinterface

// File: rtl/mc8051_mem_arb.sv
// Two-master (cpu/aux) arbiter for the mc8051 external memory/SFR port with
// fixed cpu priority, bounded aux starvation and a slave-timeout watchdog.
module mc8051_mem_arb #(
  parameter int         STARVE_LIMIT = 3,
  parameter int         TIMEOUT_CYC  = 64,
  parameter logic [7:0] TO_RDATA     = 8'hFF
) (
  input logic             clk,
  input logic             reset,
  mc8051_mem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SL_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SL_W-1:0] SL_MAX  = SL_W'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic SL_EN = (STARVE_LIMIT > 0);
  localparam logic TO_EN = (TIMEOUT_CYC > 0);

  state_t          state_q, state_d;
  logic [SL_W-1:0] starve_q, starve_d;
  logic [TO_W-1:0] to_cnt_q;

  logic        mem_we_q, mem_rd_q, mem_psen_q, mem_sfr_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic [7:0]  cpu_rdata_q, aux_rdata_q;
  logic        cpu_rdy_q, aux_rdy_q, to_err_q;
  logic [1:0]  owner_q;

  logic        cpu_req, aux_req;
  logic        grant_cpu, grant_aux;
  logic        win_we_n, win_rd_n, win_psen_n, win_sfr_n;
  logic [15:0] win_addr;
  logic [7:0]  win_wdata;
  logic        sel_we, sel_rd, sel_psen;
  logic        rdy_hit, to_hit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_cpu || grant_aux) state_d = BUSY;
      BUSY:    if (rdy_hit || to_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/decision logic: arbitration, strobe selection, completion events
  always_comb begin
    cpu_req   = ~(bus.i_cpu_we_n & bus.i_cpu_rd_n & bus.i_cpu_psen_n);
    aux_req   = ~(bus.i_aux_we_n & bus.i_aux_rd_n & bus.i_aux_psen_n);
    grant_cpu = 1'b0;
    grant_aux = 1'b0;
    starve_d  = starve_q;

    if (state_q == IDLE) begin
      if (cpu_req && aux_req) begin
        if (SL_EN && (starve_q == SL_MAX)) grant_aux = 1'b1;
        else                               grant_cpu = 1'b1;
      end else if (aux_req) begin
        grant_aux = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
      // Starvation only accumulates while aux is actually left waiting.
      if (!aux_req || grant_aux)                 starve_d = '0;
      else if (grant_cpu && (starve_q != SL_MAX)) starve_d = starve_q + 1'b1;
    end

    if (grant_aux) begin
      win_we_n   = bus.i_aux_we_n;
      win_rd_n   = bus.i_aux_rd_n;
      win_psen_n = bus.i_aux_psen_n;
      win_sfr_n  = bus.i_aux_sfr_n;
      win_addr   = bus.i_aux_addr;
      win_wdata  = bus.i_aux_wdata;
    end else begin
      win_we_n   = bus.i_cpu_we_n;
      win_rd_n   = bus.i_cpu_rd_n;
      win_psen_n = bus.i_cpu_psen_n;
      win_sfr_n  = bus.i_cpu_sfr_n;
      win_addr   = bus.i_cpu_addr;
      win_wdata  = bus.i_cpu_wdata;
    end

    // Exactly one strobe forwarded: write beats data read beats code read.
    sel_we   = ~win_we_n;
    sel_rd   = win_we_n & ~win_rd_n;
    sel_psen = win_we_n & win_rd_n & ~win_psen_n;

    rdy_hit = (state_q == BUSY) && bus.mem_data_rdy;
    to_hit  = TO_EN && (state_q == BUSY) && !bus.mem_data_rdy && (to_cnt_q == TO_LAST);
  end

  // Registered bus and completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q    <= 1'b1;
      mem_rd_q    <= 1'b1;
      mem_psen_q  <= 1'b1;
      mem_sfr_q   <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
      cpu_rdy_q   <= 1'b0;
      aux_rdy_q   <= 1'b0;
      to_err_q    <= 1'b0;
      owner_q     <= 2'b00;
      to_cnt_q    <= '0;
    end else begin
      cpu_rdy_q <= 1'b0;
      aux_rdy_q <= 1'b0;
      to_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_cpu || grant_aux) begin
            mem_we_q    <= ~sel_we;
            mem_rd_q    <= ~sel_rd;
            mem_psen_q  <= ~sel_psen;
            mem_sfr_q   <= win_sfr_n;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
            owner_q     <= grant_aux ? 2'b10 : 2'b01;
            to_cnt_q    <= '0;
          end
        end
        BUSY: begin
          if (rdy_hit || to_hit) begin
            mem_we_q   <= 1'b1;
            mem_rd_q   <= 1'b1;
            mem_psen_q <= 1'b1;
            mem_sfr_q  <= 1'b1;
            to_err_q   <= to_hit;
            if (owner_q == 2'b10) begin
              aux_rdata_q <= rdy_hit ? bus.mem_rdata : TO_RDATA;
              aux_rdy_q   <= 1'b1;
            end else begin
              cpu_rdata_q <= rdy_hit ? bus.mem_rdata : TO_RDATA;
              cpu_rdy_q   <= 1'b1;
            end
          end else if (TO_EN) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        DONE:    owner_q <= 2'b00;
        default: owner_q <= 2'b00;
      endcase
    end
  end

  assign bus.mem_we_n       = mem_we_q;
  assign bus.mem_rd_n       = mem_rd_q;
  assign bus.mem_psen_n     = mem_psen_q;
  assign bus.mem_sfr_n      = mem_sfr_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.o_cpu_rdata    = cpu_rdata_q;
  assign bus.o_cpu_data_rdy = cpu_rdy_q;
  assign bus.o_aux_rdata    = aux_rdata_q;
  assign bus.o_aux_data_rdy = aux_rdy_q;
  assign bus.o_owner        = owner_q;
  assign bus.o_timeout_err  = to_err_q;
  assign bus.fsm_state      = state_q;
  assign bus.starve_cnt     = 8'(starve_q);

endmodule

// File: tb/tb_mc8051_mem_arb.sv
// Directed bench for mc8051_mem_arb (STARVE_LIMIT=2, TIMEOUT_CYC=8):
// reset, cpu/aux transfers, strobe priority, contention, watchdog, mid-transfer reset.
module tb_mc8051_mem_arb;
  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] exp_q[$];

  mc8051_mem_arb_if bus();

  mc8051_mem_arb #(
    .STARVE_LIMIT(2),
    .TIMEOUT_CYC (8),
    .TO_RDATA    (8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish exp finish");
    $fatal(1, "simulation time limit");
  end

  // Driver tasks; a cycle starts 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.i_cpu_we_n = 1'b1; bus.i_cpu_rd_n = 1'b1; bus.i_cpu_psen_n = 1'b1; bus.i_cpu_sfr_n = 1'b1;
    bus.i_cpu_addr = 16'h0000; bus.i_cpu_wdata = 8'h00;
    bus.i_aux_we_n = 1'b1; bus.i_aux_rd_n = 1'b1; bus.i_aux_psen_n = 1'b1; bus.i_aux_sfr_n = 1'b1;
    bus.i_aux_addr = 16'h0000; bus.i_aux_wdata = 8'h00;
    bus.mem_rdata = 8'h00; bus.mem_data_rdy = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if ({bus.mem_we_n, bus.mem_rd_n, bus.mem_psen_n, bus.mem_sfr_n} !== 4'b1111) begin n_bad++; $display("FAIL reset_strobes: got %b exp 1111", {bus.mem_we_n, bus.mem_rd_n, bus.mem_psen_n, bus.mem_sfr_n}); end
    n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== 24'h0) begin n_bad++; $display("FAIL reset_addr_wdata: got %h exp 000000", {bus.mem_addr, bus.mem_wdata}); end
    n_cmp++; if ({bus.o_cpu_rdata, bus.o_aux_rdata} !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: got %h exp 0000", {bus.o_cpu_rdata, bus.o_aux_rdata}); end
    n_cmp++; if ({bus.o_cpu_data_rdy, bus.o_aux_data_rdy, bus.o_timeout_err} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b exp 000", {bus.o_cpu_data_rdy, bus.o_aux_data_rdy, bus.o_timeout_err}); end
    n_cmp++; if (bus.o_owner !== 2'b00) begin n_bad++; $display("FAIL reset_owner: got %b exp 00", bus.o_owner); end
    n_cmp++; if ({bus.fsm_state, bus.starve_cnt} !== 10'h0) begin n_bad++; $display("FAIL reset_state_starve: got %h exp 000", {bus.fsm_state, bus.starve_cnt}); end
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.fsm_state !== 2'd0) begin n_bad++; $display("FAIL reset_idle_stays: got %0d exp 0", bus.fsm_state); end
  endtask

  task automatic test_cpu_read();
    bus.i_cpu_rd_n = 1'b0; bus.i_cpu_addr = 16'h1234;
    tick();
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if ({bus.mem_rd_n, bus.mem_addr} !== {1'b0, 16'h1234}) begin n_bad++; $display("FAIL cpu_rd_bus c%0d: got %b/%h exp 0/1234", c, bus.mem_rd_n, bus.mem_addr); end
      n_cmp++; if (bus.o_owner !== 2'b01) begin n_bad++; $display("FAIL cpu_rd_owner c%0d: got %b exp 01", c, bus.o_owner); end
      if (c == 3) begin bus.mem_data_rdy = 1'b1; bus.mem_rdata = 8'hA5; end
      tick();
    end
    bus.mem_data_rdy = 1'b0;
    n_cmp++; if ({bus.o_cpu_data_rdy, bus.o_cpu_rdata} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL cpu_rd_done: got %b/%h exp 1/a5", bus.o_cpu_data_rdy, bus.o_cpu_rdata); end
    n_cmp++; if ({bus.mem_rd_n, bus.o_aux_data_rdy, bus.o_owner} !== 4'b1001) begin n_bad++; $display("FAIL cpu_rd_done_misc: got %b exp 1001", {bus.mem_rd_n, bus.o_aux_data_rdy, bus.o_owner}); end
    bus.i_cpu_rd_n = 1'b1;
    tick();
    n_cmp++; if ({bus.o_owner, bus.o_cpu_data_rdy} !== 3'b000) begin n_bad++; $display("FAIL cpu_rd_idle: got %b exp 000", {bus.o_owner, bus.o_cpu_data_rdy}); end
    tick();
    n_cmp++; if (bus.mem_rd_n !== 1'b1) begin n_bad++; $display("FAIL cpu_rd_no_retrigger: got %b exp 1", bus.mem_rd_n); end
  endtask

  task automatic test_strobe_priority();
    bus.i_cpu_we_n = 1'b0; bus.i_cpu_rd_n = 1'b0; bus.i_cpu_addr = 16'h0042; bus.i_cpu_wdata = 8'h3C;
    tick();
    n_cmp++; if ({bus.mem_we_n, bus.mem_rd_n, bus.mem_psen_n} !== 3'b011) begin n_bad++; $display("FAIL prio_strobes: got %b exp 011", {bus.mem_we_n, bus.mem_rd_n, bus.mem_psen_n}); end
    n_cmp++; if (bus.mem_wdata !== 8'h3C) begin n_bad++; $display("FAIL prio_wdata: got %h exp 3c", bus.mem_wdata); end
    bus.mem_data_rdy = 1'b1; bus.mem_rdata = 8'h77;
    tick();
    bus.mem_data_rdy = 1'b0;
    n_cmp++; if ({bus.o_cpu_data_rdy, bus.o_cpu_rdata} !== {1'b1, 8'h77}) begin n_bad++; $display("FAIL prio_write_capture: got %b/%h exp 1/77", bus.o_cpu_data_rdy, bus.o_cpu_rdata); end
    bus.i_cpu_we_n = 1'b1; bus.i_cpu_rd_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_aux_wait();
    bus.i_cpu_rd_n = 1'b0; bus.i_cpu_addr = 16'h2000;
    tick();
    bus.i_aux_we_n = 1'b0; bus.i_aux_sfr_n = 1'b0; bus.i_aux_addr = 16'h0080; bus.i_aux_wdata = 8'h5A;
    n_cmp++; if ({bus.o_owner, bus.mem_we_n, bus.o_aux_data_rdy} !== 4'b0110) begin n_bad++; $display("FAIL aux_wait_busy: got %b exp 0110", {bus.o_owner, bus.mem_we_n, bus.o_aux_data_rdy}); end
    tick();
    bus.mem_data_rdy = 1'b1; bus.mem_rdata = 8'h11;
    tick();
    bus.mem_data_rdy = 1'b0;
    n_cmp++; if ({bus.o_cpu_data_rdy, bus.o_aux_data_rdy, bus.o_cpu_rdata} !== {2'b10, 8'h11}) begin n_bad++; $display("FAIL aux_wait_cpu_done: got %b%b/%h exp 10/11", bus.o_cpu_data_rdy, bus.o_aux_data_rdy, bus.o_cpu_rdata); end
    bus.i_cpu_rd_n = 1'b1;
    tick();
    n_cmp++; if ({bus.o_owner, bus.o_aux_data_rdy} !== 3'b000) begin n_bad++; $display("FAIL aux_wait_idle: got %b exp 000", {bus.o_owner, bus.o_aux_data_rdy}); end
    tick();
    n_cmp++; if ({bus.mem_we_n, bus.mem_rd_n, bus.mem_sfr_n, bus.o_owner} !== 5'b01010) begin n_bad++; $display("FAIL aux_wr_strobes: got %b exp 01010", {bus.mem_we_n, bus.mem_rd_n, bus.mem_sfr_n, bus.o_owner}); end
    n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== {16'h0080, 8'h5A}) begin n_bad++; $display("FAIL aux_wr_addr_data: got %h exp 00805a", {bus.mem_addr, bus.mem_wdata}); end
    bus.mem_data_rdy = 1'b1; bus.mem_rdata = 8'h99;
    tick();
    bus.mem_data_rdy = 1'b0;
    n_cmp++; if ({bus.o_aux_data_rdy, bus.o_aux_rdata, bus.o_cpu_data_rdy, bus.o_cpu_rdata} !== {1'b1, 8'h99, 1'b0, 8'h11}) begin n_bad++; $display("FAIL aux_wr_done: got %b/%h/%b/%h exp 1/99/0/11", bus.o_aux_data_rdy, bus.o_aux_rdata, bus.o_cpu_data_rdy, bus.o_cpu_rdata); end
    bus.i_aux_we_n = 1'b1; bus.i_aux_sfr_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_timeout();
    bus.i_cpu_psen_n = 1'b0; bus.i_cpu_addr = 16'h0100;
    tick();
    for (int c = 1; c <= 8; c++) begin
      n_cmp++; if ({bus.mem_psen_n, bus.o_cpu_data_rdy, bus.o_timeout_err} !== 3'b000) begin n_bad++; $display("FAIL to_hold c%0d: got %b exp 000", c, {bus.mem_psen_n, bus.o_cpu_data_rdy, bus.o_timeout_err}); end
      tick();
    end
    n_cmp++; if ({bus.o_cpu_data_rdy, bus.o_cpu_rdata, bus.o_timeout_err, bus.mem_psen_n} !== {1'b1, 8'hFF, 2'b11}) begin n_bad++; $display("FAIL to_abort c9: got %b/%h/%b/%b exp 1/ff/1/1", bus.o_cpu_data_rdy, bus.o_cpu_rdata, bus.o_timeout_err, bus.mem_psen_n); end
    bus.i_cpu_psen_n = 1'b1;
    tick();
    n_cmp++; if ({bus.o_timeout_err, bus.o_owner} !== 3'b000) begin n_bad++; $display("FAIL to_pulse_end: got %b exp 000", {bus.o_timeout_err, bus.o_owner}); end
    bus.i_cpu_rd_n = 1'b0; bus.i_cpu_addr = 16'h0005;
    tick();
    n_cmp++; if ({bus.mem_rd_n, bus.mem_addr} !== {1'b0, 16'h0005}) begin n_bad++; $display("FAIL to_recover_bus: got %b/%h exp 0/0005", bus.mem_rd_n, bus.mem_addr); end
    bus.mem_data_rdy = 1'b1; bus.mem_rdata = 8'h42;
    tick();
    bus.mem_data_rdy = 1'b0; bus.i_cpu_rd_n = 1'b1;
    n_cmp++; if ({bus.o_cpu_data_rdy, bus.o_cpu_rdata, bus.o_timeout_err} !== {1'b1, 8'h42, 1'b0}) begin n_bad++; $display("FAIL to_recover_done: got %b/%h/%b exp 1/42/0", bus.o_cpu_data_rdy, bus.o_cpu_rdata, bus.o_timeout_err); end
    tick();
    // Ready arriving on the last allowed cycle is a normal completion.
    bus.i_cpu_psen_n = 1'b0; bus.i_cpu_addr = 16'h0200;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) begin bus.mem_data_rdy = 1'b1; bus.mem_rdata = 8'h5C; end
      tick();
    end
    bus.mem_data_rdy = 1'b0; bus.i_cpu_psen_n = 1'b1;
    n_cmp++; if ({bus.o_cpu_data_rdy, bus.o_cpu_rdata, bus.o_timeout_err} !== {1'b1, 8'h5C, 1'b0}) begin n_bad++; $display("FAIL to_edge_rdy: got %b/%h/%b exp 1/5c/0", bus.o_cpu_data_rdy, bus.o_cpu_rdata, bus.o_timeout_err); end
    tick();
  endtask

  task automatic test_ignore_rdy();
    bus.mem_data_rdy = 1'b1; bus.mem_rdata = 8'hEE;
    tick(); tick();
    bus.mem_data_rdy = 1'b0;
    n_cmp++; if ({bus.o_cpu_data_rdy, bus.o_aux_data_rdy, bus.o_cpu_rdata, bus.fsm_state} !== {2'b00, 8'h5C, 2'd0}) begin n_bad++; $display("FAIL idle_rdy_ignored: got %b%b/%h/%0d exp 00/5c/0", bus.o_cpu_data_rdy, bus.o_aux_data_rdy, bus.o_cpu_rdata, bus.fsm_state); end
  endtask

  task automatic test_back_to_back();
    bit found;
    logic [1:0]  exp_owner;
    logic [15:0] exp_addr;
    exp_q = {2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    bus.i_cpu_rd_n = 1'b0; bus.i_cpu_addr = 16'h1000;
    bus.i_aux_rd_n = 1'b0; bus.i_aux_addr = 16'h2000;
    bus.mem_data_rdy = 1'b1; bus.mem_rdata = 8'hC3;
    for (int g = 0; g < 6; g++) begin
      found = 1'b0;
      for (int w = 0; w < 10; w++) begin
        if (bus.mem_rd_n === 1'b0) begin found = 1'b1; break; end
        tick();
      end
      exp_owner = exp_q.pop_front();
      exp_addr  = (exp_owner == 2'b10) ? 16'h2000 : 16'h1000;
      n_cmp++; if (!found) begin n_bad++; $display("FAIL b2b_grant_wait g%0d: got none exp grant", g); end
      n_cmp++; if ({bus.o_owner, bus.mem_addr} !== {exp_owner, exp_addr}) begin n_bad++; $display("FAIL b2b_owner g%0d: got %b/%h exp %b/%h", g, bus.o_owner, bus.mem_addr, exp_owner, exp_addr); end
      tick();
      n_cmp++; if ({bus.o_cpu_data_rdy, bus.o_aux_data_rdy} !== {exp_owner[0], exp_owner[1]}) begin n_bad++; $display("FAIL b2b_done g%0d: got %b%b exp %b%b", g, bus.o_cpu_data_rdy, bus.o_aux_data_rdy, exp_owner[0], exp_owner[1]); end
      if (g == 5) begin bus.i_cpu_rd_n = 1'b1; bus.i_aux_rd_n = 1'b1; end
    end
    bus.mem_data_rdy = 1'b0;
    tick(); tick();
    n_cmp++; if ({bus.mem_rd_n, bus.o_owner} !== 3'b100) begin n_bad++; $display("FAIL b2b_quiet: got %b exp 100", {bus.mem_rd_n, bus.o_owner}); end
  endtask

  task automatic test_reset_mid();
    bus.i_aux_rd_n = 1'b0; bus.i_aux_addr = 16'h3333;
    tick();
    tick();
    reset = 1'b1; bus.mem_data_rdy = 1'b1; bus.mem_rdata = 8'h66;
    tick();
    reset = 1'b0; bus.mem_data_rdy = 1'b0; bus.i_aux_rd_n = 1'b1;
    n_cmp++; if ({bus.mem_we_n, bus.mem_rd_n, bus.mem_psen_n, bus.mem_sfr_n, bus.o_owner} !== 6'b111100) begin n_bad++; $display("FAIL rst_mid_bus: got %b exp 111100", {bus.mem_we_n, bus.mem_rd_n, bus.mem_psen_n, bus.mem_sfr_n, bus.o_owner}); end
    n_cmp++; if ({bus.o_aux_data_rdy, bus.o_cpu_data_rdy, bus.starve_cnt, bus.fsm_state} !== 12'h0) begin n_bad++; $display("FAIL rst_mid_state: got %b%b/%h/%0d exp 00/00/0", bus.o_aux_data_rdy, bus.o_cpu_data_rdy, bus.starve_cnt, bus.fsm_state); end
    tick();
    n_cmp++; if ({bus.o_aux_data_rdy, bus.o_aux_rdata} !== 9'h0) begin n_bad++; $display("FAIL rst_mid_no_pulse: got %b/%h exp 0/00", bus.o_aux_data_rdy, bus.o_aux_rdata); end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_cpu_read();
    test_strobe_priority();
    test_aux_wait();
    test_timeout();
    test_ignore_rdy();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc8051_mem_arb.md
Name: mc8051_mem_arb

Overview:
- Two-master arbiter for the single external memory port of the mc8051 core.
- Shares one memory/SFR bus between the CPU bus interface (cpu port) and an auxiliary master such as DMA or a debug loader (aux port).
- Masters use the core's native active-low strobe handshake and get one completion pulse per transaction.
- Fixed CPU priority, bounded aux starvation, and a timeout watchdog so a dead slave cannot hang the core.

Parameters:
- STARVE_LIMIT, 3: consecutive lost arbitrations after which the waiting aux master is granted ahead of the CPU; 0 means aux always loses to a simultaneous CPU request.
- TIMEOUT_CYC, 64: maximum number of cycles the slave strobe is held without mem_data_rdy; 0 disables the watchdog.
- TO_RDATA, 8'hFF: read data returned to the master on timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_cpu_we_n / i_cpu_rd_n / i_cpu_psen_n / i_cpu_sfr_n  in  1 each  CPU write, data-read, code-read and SFR-space strobes; active low.
- i_cpu_addr  in  16  CPU address.
- i_cpu_wdata  in  8  CPU write data.
- o_cpu_rdata  out  8  CPU read data; valid with o_cpu_data_rdy.
- o_cpu_data_rdy  out  1  one-cycle CPU completion pulse.
- i_aux_we_n / i_aux_rd_n / i_aux_psen_n / i_aux_sfr_n  in  1 each  aux strobes; same meaning as the CPU strobes.
- i_aux_addr  in  16  aux address.
- i_aux_wdata  in  8  aux write data.
- o_aux_rdata  out  8  aux read data.
- o_aux_data_rdy  out  1  one-cycle aux completion pulse.
- mem_we_n / mem_rd_n / mem_psen_n / mem_sfr_n  out  1 each  registered slave strobes; active low.
- mem_addr  out  16  registered slave address.
- mem_wdata  out  8  registered slave write data.
- mem_rdata  in  8  slave read data.
- mem_data_rdy  in  1  slave completion; active high, sampled only while a strobe is asserted.
- o_owner  out  2  current owner: 00 none, 01 cpu, 10 aux.
- o_timeout_err  out  1  one-cycle pulse when a transaction is aborted by the watchdog.

Behaviour:
- Reset:
  - All mem_* strobes 1; mem_addr 0; mem_wdata 0.
  - o_*_rdata 0; o_*_data_rdy 0; o_owner 00; o_timeout_err 0.
  - Starvation counter 0; timeout counter 0; state IDLE.
  - A reset in any state aborts the transaction at once: no completion pulse is issued and strobes are high in the cycle after reset.
- Request: a master requests when any of its we_n/rd_n/psen_n is 0. The sfr_n strobe alone is not a request; it qualifies the access and is forwarded with it.
- Multiple strobes low on one master: only one is forwarded, priority we > rd > psen.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - Only aux requests: grant aux.
  - Only CPU requests: grant CPU.
  - Both request: grant aux if starve_cnt == STARVE_LIMIT (with STARVE_LIMIT > 0), otherwise grant CPU and increment starve_cnt (saturates at STARVE_LIMIT).
  - starve_cnt clears on every aux grant and whenever aux is not requesting in IDLE.
  - On a grant, the winner's strobe, sfr_n, addr and wdata are registered onto the mem_* outputs. o_owner is set and the state goes to BUSY on the next edge, so latency from request to slave strobe is 1 cycle.
- BUSY:
  - mem_* outputs are held constant; granted-master inputs are not re-sampled.
  - On mem_data_rdy=1: capture mem_rdata into the owner's o_*_rdata (write transactions capture it too) and go to DONE.
  - Timeout counter starts at 0 on BUSY entry and increments each BUSY cycle without mem_data_rdy. If TIMEOUT_CYC != 0 and the count reaches TIMEOUT_CYC-1 with no mem_data_rdy, load TO_RDATA into o_*_rdata and go to DONE with the timeout flag set.
  - mem_data_rdy in the same cycle as the timeout limit counts as a normal completion.
- DONE (exactly 1 cycle):
  - mem_* strobes high; owner's o_*_data_rdy = 1.
  - o_timeout_err = 1 if the timeout flag is set.
  - o_owner stays the same; returns to 00 on the IDLE entry edge.
- Master rule: strobes are held stable from request until the data_rdy pulse. Strobes still low in the IDLE cycle after DONE are a new transaction, which makes back-to-back accesses legal.
- The non-owning master's o_*_data_rdy is always 0. Its o_*_rdata holds its last value.
- mem_data_rdy arriving in IDLE or DONE is ignored.
- Minimum transaction length is 4 cycles (IDLE, BUSY, DONE, IDLE).

Test Plan:
- CPU read alone: i_cpu_rd_n=0, i_cpu_addr=16'h1234 at cycle 0; mem_data_rdy=1 with mem_rdata=8'hA5 at cycle 3 -> mem_rd_n=0 and mem_addr=16'h1234 in cycles 1-3; o_cpu_data_rdy=1 and o_cpu_rdata=8'hA5 at cycle 4; mem_rd_n=1 at cycle 4; o_owner=00 at cycle 5.
- Contention, STARVE_LIMIT=2, both masters continuously requesting, slave rdy after 1 BUSY cycle -> grant order cpu, cpu, aux, cpu, cpu, aux; aux never waits more than 3 grants.
- Aux write (i_aux_we_n=0, addr 16'h0080, wdata 8'h5A, i_aux_sfr_n=0) issued during a CPU transaction -> aux waits, o_aux_data_rdy=0; after CPU DONE, mem_we_n=0, mem_sfr_n=0, mem_addr=16'h0080, mem_wdata=8'h5A.
- TIMEOUT_CYC=8, CPU psen read, mem_data_rdy held 0 -> mem_psen_n=0 for exactly cycles 1-8; cycle 9: o_cpu_data_rdy=1, o_cpu_rdata=8'hFF, o_timeout_err=1; next request is arbitrated normally.
- reset=1 in cycle 2 of an aux transaction -> cycle 3: all strobes 1, o_owner=00, no data_rdy pulse, starve_cnt=0.
- CPU with i_cpu_we_n=0 and i_cpu_rd_n=0 together -> only mem_we_n=0 forwarded, mem_rd_n stays 1.
